blctrl_i2c_scheduler: RTL
=========================

Name: blctrl_i2c_scheduler

Overview:
- Parametrised successor to the fixed 8-motor BL-Ctrl handler.
- Round-robins I2C write transactions, one speed byte per ESC, across NUM_MOTORS BL-Ctrl ESCs.
- Refresh rate is programmable; address map is configurable.
- Reports per-motor NACK status.
- Drives open-drain SCL/SDA through external IOBUF-style tristate pins (*_t=1 means released).

Parameters:
- NUM_MOTORS, 8: number of ESC channels (1..16).
- BASE_ADDR, 8'h52: 8-bit write address of motor 0 (R/W bit = 0).
- ADDR_STEP, 2: 8-bit address increment per motor.
- QUARTER_CYCLES, 40: clk cycles per SCL quarter-bit (16 MHz clk gives 100 kHz SCL).
- REFRESH_CYCLES, 160000: clk cycles between frame starts (100 Hz at 16 MHz).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- masterEnable  in  1  global arm; 0 forces all transmitted speeds to 0.
- motorEnable  in  NUM_MOTORS  per-motor arm; 0 forces that motor's speed to 0.
- targetSpeedFlat  in  8*NUM_MOTORS  motor i speed in bits [8i+7:8i].
- scl_i  in  1  SCL pin readback.
- scl_o  out  1  SCL drive value, constant 0.
- scl_t  out  1  SCL tristate; 1 = released.
- sda_i  in  1  SDA pin readback.
- sda_o  out  1  SDA drive value, constant 0.
- sda_t  out  1  SDA tristate; 1 = released.
- busy  out  1  high while a frame is in progress.
- frame_done  out  1  one-cycle pulse when a frame completes.
- nack_flags  out  NUM_MOTORS  bit i = 1 if motor i's last transaction saw any NACK.

Behaviour:
- Reset values: scl_t=1, sda_t=1, scl_o=0, sda_o=0, busy=0, frame_done=0, nack_flags=0, refresh counter=0, pending=0.
- Reset asserted mid-transaction releases both lines immediately. No STOP is generated.
- Refresh counter counts 0..REFRESH_CYCLES-1 and wraps. Each wrap raises a frame request.
  - Request while idle: frame starts next cycle.
  - Request while busy: sets pending (a single bit); further requests are dropped.
  - Pending frame starts on the cycle after frame_done.
- Frame: motors 0..NUM_MOTORS-1 in order; every motor is addressed regardless of enable.
  - Speed byte is latched at that motor's START: 0 if !masterEnable or !motorEnable[i], else targetSpeedFlat slice.
- Address byte = BASE_ADDR + i*ADDR_STEP, truncated to 8 bits, sent MSB first.
- FSM states: IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP, GAP. Each quarter lasts QUARTER_CYCLES clk.
  - START (4Q): q0 SDA rel/SCL rel; q1 SDA low/SCL rel; q2 and q3 SDA low/SCL low.
  - Data bit (4Q): SDA set at start of q0 with SCL low; q1 SCL low; q2 and q3 SCL released.
  - ACK bit: SDA released for all 4Q. sda_i is sampled on the last clk of q2; 1 = NACK.
  - ADDR NACK: skip DATA, go to STOP, set nack_flags[i].
  - DATA NACK: go to STOP, set nack_flags[i].
  - nack_flags[i] is cleared when motor i completes with both ACKs.
  - STOP (4Q): q0 SCL low/SDA low; q1 SCL rel/SDA low; q2 and q3 both released.
  - GAP (4Q): bus free, both released. Then the next motor's START, or IDLE after the last motor.
- Transaction length (no stretching): 84*QUARTER_CYCLES clk with ACKs; 48*QUARTER_CYCLES on address NACK.
- busy rises the cycle a frame leaves IDLE. busy falls and frame_done pulses on the cycle the FSM returns to IDLE.
- nack_flags are updated at the end of each motor's STOP and held between frames.

Optional Feature:
- Macro BLCTRL_CLOCK_STRETCH_EN.
- Defined: in any quarter where scl_t=1, the quarter counter holds while scl_i==0. Counting resumes after scl_i reads 1; an ESC holding SCL low therefore extends the bit.
- Undefined: scl_i is ignored and timing is fixed.

Test Plan:
- QUARTER_CYCLES=2, NUM_MOTORS=2, masterEnable=1, motorEnable=2'b11, speeds 8'h80/8'h85, slave model ACKs all -> bus shows 0x52,0x80 then 0x54,0x85; nack_flags=0; frame_done at cycle 1+2*84*2.
- masterEnable=0, speeds 8'h80 -> both data bytes are 0x00; addresses still sent.
- Slave NACKs address 0x54 -> motor 1 has no data byte, STOP follows; nack_flags=2'b10. Next frame with ACK clears it to 2'b00.
- REFRESH_CYCLES=100 (shorter than a frame) -> exactly one pending frame starts the cycle after frame_done; extra requests are dropped.
- Assert rst in the middle of the ADDR phase -> scl_t=sda_t=1, busy=0, nack_flags=0 asynchronously; first frame starts after the next refresh wrap.
- BLCTRL_CLOCK_STRETCH_EN defined, slave holds SCL low 10 cycles during the ACK high phase -> that bit lasts 4*2+10 cycles and the ACK is still sampled. Undefined -> bit stays 8 cycles.

Source files
------------

// File: rtl/blctrl_i2c_scheduler.sv
// blctrl_i2c_scheduler: round-robin I2C speed writer for NUM_MOTORS BL-Ctrl ESCs
// Ports: clk/rst (async, active high); masterEnable/motorEnable/targetSpeedFlat select speeds;
// scl_*/sda_* drive IOBUF-style open-drain pins (*_t=1 released); busy/frame_done report frames;
// nack_flags hold per-motor NACK status. Macro BLCTRL_CLOCK_STRETCH_EN enables SCL clock stretching.
module blctrl_i2c_scheduler #(
  parameter int NUM_MOTORS = 8,
  parameter logic [7:0] BASE_ADDR = 8'h52,
  parameter int ADDR_STEP = 2,
  parameter int QUARTER_CYCLES = 40,
  parameter int REFRESH_CYCLES = 160000
) (
  input  logic clk,
  input  logic rst,
  input  logic masterEnable,
  input  logic [NUM_MOTORS-1:0] motorEnable,
  input  logic [8*NUM_MOTORS-1:0] targetSpeedFlat,
  input  logic scl_i,
  output logic scl_o,
  output logic scl_t,
  input  logic sda_i,
  output logic sda_o,
  output logic sda_t,
  output logic busy,
  output logic frame_done,
  output logic [NUM_MOTORS-1:0] nack_flags
);
  localparam int MW = NUM_MOTORS > 1 ? $clog2(NUM_MOTORS) : 1;
  localparam int QW = QUARTER_CYCLES > 1 ? $clog2(QUARTER_CYCLES) : 1;
  localparam int RW = REFRESH_CYCLES > 1 ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, ADDR = 3'd2, ADDR_ACK = 3'd3,
                         DATA = 3'd4, DATA_ACK = 3'd5, STOP = 3'd6, GAP = 3'd7;
  logic [2:0] state_q, state_d, bit_q, bit_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [1:0] quarter_q, quarter_d;
  logic [MW-1:0] motor_q, motor_d;
  logic [7:0] sh_q, sh_d, data_q, data_d;
  logic [RW-1:0] refresh_q, refresh_d;
  logic [NUM_MOTORS-1:0] flags_q, flags_d;
  logic pending_q, pending_d, done_q, done_d, nack_q, nack_d;
  logic hold, qend, bend, req, is_bit;
  assign scl_o = 1'b0;
  assign sda_o = 1'b0;
  assign busy = state_q != IDLE;
  assign frame_done = done_q;
  assign nack_flags = flags_q;
  always_comb begin
    is_bit = state_q inside {ADDR, ADDR_ACK, DATA, DATA_ACK};
    scl_t = state_q == START ? !quarter_q[1] : is_bit ? quarter_q[1] : state_q == STOP ? quarter_q != 2'd0 : 1'b1;
    sda_t = state_q == START ? quarter_q == 2'd0 : (state_q == ADDR || state_q == DATA) ? sh_q[7] :
            state_q == STOP ? quarter_q[1] : 1'b1;
  end
`ifdef BLCTRL_CLOCK_STRETCH_EN
  assign hold = scl_t && !scl_i;
`else
  logic unused_scl_i;
  assign hold = 1'b0;
  assign unused_scl_i = scl_i;
`endif
  assign qend = state_q != IDLE && !hold && qcnt_q == QW'(QUARTER_CYCLES - 1);
  assign bend = qend && quarter_q == 2'd3;
  assign req = refresh_q == RW'(REFRESH_CYCLES - 1);
  always_comb begin
    refresh_d = req ? '0 : refresh_q + 1'b1;
    qcnt_d = (state_q == IDLE || hold) ? qcnt_q : qend ? '0 : qcnt_q + 1'b1;
    quarter_d = qend ? quarter_q + 2'd1 : quarter_q;
    state_d = state_q;
    bit_d = bit_q;
    motor_d = motor_q;
    sh_d = sh_q;
    data_d = data_q;
    nack_d = nack_q;
    flags_d = flags_q;
    done_d = 1'b0;
    pending_d = pending_q;
    if (state_q == IDLE) begin
      if (req || pending_q) begin
        state_d = START;
        motor_d = '0;
        pending_d = 1'b0;
      end
    end else if (req) pending_d = 1'b1;
    // ACK is sampled on the last clk of the third quarter; a released SDA means NACK
    if ((state_q == ADDR_ACK || state_q == DATA_ACK) && qend && quarter_q == 2'd2 && sda_i) nack_d = 1'b1;
    if (bend)
      case (state_q)
        START: state_d = ADDR;
        ADDR, DATA: begin
          sh_d = {sh_q[6:0], 1'b0};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = state_q + 3'd1;
        end
        ADDR_ACK: begin
          state_d = nack_q ? STOP : DATA;
          sh_d = data_q;
        end
        DATA_ACK: state_d = STOP;
        STOP: begin
          state_d = GAP;
          flags_d[motor_q] = nack_q;
        end
        GAP: begin
          state_d = motor_q == MW'(NUM_MOTORS - 1) ? IDLE : START;
          done_d = motor_q == MW'(NUM_MOTORS - 1);
          motor_d = motor_q == MW'(NUM_MOTORS - 1) ? motor_q : motor_q + 1'b1;
        end
        default: ;
      endcase
    // address and speed are captured as each motor's START begins
    if (state_d == START && state_q != START) begin
      sh_d = BASE_ADDR + 8'(ADDR_STEP * int'(motor_d));
      data_d = (masterEnable && motorEnable[motor_d]) ? 8'(targetSpeedFlat >> {motor_d, 3'b000}) : 8'h00;
      nack_d = 1'b0;
      bit_d = 3'd0;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      bit_q <= '0;
      qcnt_q <= '0;
      quarter_q <= '0;
      motor_q <= '0;
      sh_q <= '0;
      data_q <= '0;
      refresh_q <= '0;
      flags_q <= '0;
      pending_q <= 1'b0;
      done_q <= 1'b0;
      nack_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q <= bit_d;
      qcnt_q <= qcnt_d;
      quarter_q <= quarter_d;
      motor_q <= motor_d;
      sh_q <= sh_d;
      data_q <= data_d;
      refresh_q <= refresh_d;
      flags_q <= flags_d;
      pending_q <= pending_d;
      done_q <= done_d;
      nack_q <= nack_d;
    end
endmodule
